// File: rtl/saturn_mem_bridge.sv
// Saturn external-memory strobe bridge: folds BIOS ROM / low / high work RAM
// into one 4 MB single-outstanding valid/ready request with a one-word read buffer.
module saturn_mem_bridge #(
   parameter logic [21:0] ROM_BASE  = 22'h000000,
   parameter logic [21:0] RAML_BASE = 22'h100000,
   parameter logic [21:0] RAMH_BASE = 22'h200000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [24:0] MEM_A,
   input  logic [31:0] MEM_DO,
   input  logic [3:0]  MEM_DQM_N,
   input  logic        MEM_RD_N,
   input  logic        ROM_CS_N,
   input  logic        RAML_CS_N,
   input  logic        RAMH_CS_N,
   output logic [31:0] MEM_DI,
   output logic        MEM_WAIT_N,
   output logic        REQ_VALID,
   input  logic        REQ_READY,
   output logic        REQ_WR,
   output logic [21:0] REQ_ADDR,
   output logic [3:0]  REQ_BE,
   output logic [31:0] REQ_WDATA,
   input  logic        RSP_VALID,
   input  logic [31:0] RSP_RDATA
);

   localparam int unsigned AW = 22;
   localparam int unsigned DW = 32;
   localparam int unsigned KW = 26;

   localparam logic [1:0] RG_NONE = 2'd0;
   localparam logic [1:0] RG_ROM  = 2'd1;
   localparam logic [1:0] RG_RAML = 2'd2;
   localparam logic [1:0] RG_RAMH = 2'd3;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_RSP, ST_DONE} state_t;

   state_t        state_q;
   logic [1:0]    region;
   logic [AW-1:0] map_addr;
   logic [KW-1:0] key;
   logic [KW-1:0] key_q;
   logic          any_cs;
   logic          new_acc;
   logic          buf_hit;
   logic          buf_v_q;
   logic [AW-1:0] buf_addr_q;
   logic [DW-1:0] buf_data_q;
   logic          unused_addr_lsb;

   assign unused_addr_lsb = ^MEM_A[1:0];

   // Region decode (RAMH > RAML > ROM) and word-aligned byte address in request space
   always_comb begin
      region   = RG_NONE;
      map_addr = '0;
      if (!RAMH_CS_N) begin
         region   = RG_RAMH;
         map_addr = RAMH_BASE | {2'b00, MEM_A[19:2], 2'b00};
      end else if (!RAML_CS_N) begin
         region   = RG_RAML;
         map_addr = RAML_BASE | {2'b00, MEM_A[19:2], 2'b00};
      end else if (!ROM_CS_N) begin
         region   = RG_ROM;
         map_addr = ROM_BASE | {3'b000, MEM_A[18:2], 2'b00};
      end
   end

   // A held strobe set is only new once: DONE compares against the access it just served
   assign any_cs     = (region != RG_NONE);
   assign key        = {MEM_A[24:2], MEM_RD_N, region};
   assign new_acc    = any_cs && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && (key != key_q)));
   assign buf_hit    = buf_v_q && (buf_addr_q == map_addr);
   assign MEM_WAIT_N = !(new_acc || (state_q == ST_ISSUE) || (state_q == ST_WAIT_RSP));

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         key_q      <= '0;
         buf_v_q    <= 1'b0;
         buf_addr_q <= '0;
         buf_data_q <= '0;
         MEM_DI     <= '0;
         REQ_VALID  <= 1'b0;
         REQ_WR     <= 1'b0;
         REQ_ADDR   <= '0;
         REQ_BE     <= '0;
         REQ_WDATA  <= '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (new_acc) begin
                  key_q <= key;
                  if (!MEM_RD_N) begin
                     if (buf_hit) begin
                        MEM_DI  <= buf_data_q;
                        state_q <= ST_DONE;
                     end else begin
                        REQ_VALID <= 1'b1;
                        REQ_WR    <= 1'b0;
                        REQ_ADDR  <= map_addr;
                        REQ_BE    <= 4'hF;
                        REQ_WDATA <= '0;
                        state_q   <= ST_ISSUE;
                     end
                  end else if ((region == RG_ROM) || (MEM_DQM_N == 4'hF)) begin
                     // ROM writes and fully masked writes complete without touching memory
                     state_q <= ST_DONE;
                  end else begin
                     REQ_VALID <= 1'b1;
                     REQ_WR    <= 1'b1;
                     REQ_ADDR  <= map_addr;
                     REQ_BE    <= ~MEM_DQM_N;
                     REQ_WDATA <= MEM_DO;
                     state_q   <= ST_ISSUE;
                  end
               end else if (!any_cs) begin
                  state_q <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               if (REQ_READY) begin
                  REQ_VALID <= 1'b0;
                  if (REQ_WR) begin
                     if (buf_addr_q == REQ_ADDR) begin
                        buf_v_q <= 1'b0;
                     end
                     state_q <= ST_DONE;
                  end else begin
                     state_q <= ST_WAIT_RSP;
                  end
               end
            end
            ST_WAIT_RSP: begin
               if (RSP_VALID) begin
                  MEM_DI     <= RSP_RDATA;
                  buf_v_q    <= 1'b1;
                  buf_addr_q <= REQ_ADDR;
                  buf_data_q <= RSP_RDATA;
                  state_q    <= ST_DONE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_saturn_mem_bridge.sv
// Directed bench for saturn_mem_bridge: a responder plays the memory controller,
// request and read-data scoreboards hold the expected traffic.
module tb_saturn_mem_bridge;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [24:0] MEM_A = '0;
   logic [31:0] MEM_DO = '0;
   logic [3:0]  MEM_DQM_N = 4'hF;
   logic        MEM_RD_N = 1'b1;
   logic        ROM_CS_N = 1'b1;
   logic        RAML_CS_N = 1'b1;
   logic        RAMH_CS_N = 1'b1;
   logic [31:0] MEM_DI;
   logic        MEM_WAIT_N;
   logic        REQ_VALID;
   logic        REQ_READY = 1'b0;
   logic        REQ_WR;
   logic [21:0] REQ_ADDR;
   logic [3:0]  REQ_BE;
   logic [31:0] REQ_WDATA;
   logic        RSP_VALID = 1'b0;
   logic [31:0] RSP_RDATA = '0;

   int total = 0;
   int bad = 0;
   int n_acc = 0;

   logic [58:0] exp_req_q[$];
   logic [31:0] rd_q[$];

   int          ready_dly = 0;
   int          rsp_dly = 2;
   logic [31:0] rsp_word = '0;

   saturn_mem_bridge dut (
      .CLK(CLK), .RST(RST), .MEM_A(MEM_A), .MEM_DO(MEM_DO), .MEM_DQM_N(MEM_DQM_N),
      .MEM_RD_N(MEM_RD_N), .ROM_CS_N(ROM_CS_N), .RAML_CS_N(RAML_CS_N), .RAMH_CS_N(RAMH_CS_N),
      .MEM_DI(MEM_DI), .MEM_WAIT_N(MEM_WAIT_N), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
      .REQ_WR(REQ_WR), .REQ_ADDR(REQ_ADDR), .REQ_BE(REQ_BE), .REQ_WDATA(REQ_WDATA),
      .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor: accepted requests against the scoreboard, payload stability under backpressure
   logic [58:0] hold;
   bit          hold_v = 1'b0;
   always @(posedge CLK) begin
      if (RST) begin
         hold_v = 1'b0;
      end else if (REQ_VALID) begin
         if (hold_v) check("req_stable", 64'({REQ_WR, REQ_ADDR, REQ_BE, REQ_WDATA}), 64'(hold));
         hold   = {REQ_WR, REQ_ADDR, REQ_BE, REQ_WDATA};
         hold_v = 1'b1;
         if (REQ_READY) begin
            logic [58:0] e;
            n_acc++;
            hold_v = 1'b0;
            e = (exp_req_q.size() != 0) ? exp_req_q.pop_front() : '1;
            check("req_payload", 64'({REQ_WR, REQ_ADDR, REQ_BE, REQ_WDATA}), 64'(e));
         end
      end
   end

   // Responder: READY after ready_dly waiting cycles, read data rsp_dly cycles after accept
   int vcnt = 0;
   int rsp_cnt = 0;
   bit rsp_pend = 1'b0;
   bit cur_wr = 1'b0;
   always @(negedge CLK) begin
      RSP_VALID = 1'b0;
      if (REQ_READY) begin
         REQ_READY = 1'b0;
         if (!cur_wr) begin
            rsp_pend = 1'b1;
            rsp_cnt  = 1;
         end
      end else if (REQ_VALID) begin
         if (vcnt >= ready_dly) begin
            REQ_READY = 1'b1;
            cur_wr    = REQ_WR;
            vcnt      = 0;
         end else begin
            vcnt++;
         end
      end
      if (rsp_pend) begin
         if (rsp_cnt >= rsp_dly) begin
            RSP_VALID = 1'b1;
            RSP_RDATA = rsp_word;
            rsp_pend  = 1'b0;
         end else begin
            rsp_cnt++;
         end
      end
   end

   // One CPU bus cycle: drive strobes, count stall cycles, check read data
   task automatic access(input string tag, input logic [2:0] cs_n, input logic [24:0] a,
                         input logic rd_n, input logic [3:0] dqm_n, input logic [31:0] wd,
                         input int exp_stall, input bit rel);
      int stall;
      bit done;
      logic [31:0] ed;
      {RAMH_CS_N, RAML_CS_N, ROM_CS_N} = cs_n;
      MEM_A = a; MEM_RD_N = rd_n; MEM_DQM_N = dqm_n; MEM_DO = wd;
      stall = 0;
      done  = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge CLK);
         if (MEM_WAIT_N) done = 1'b1;
         else stall++;
      end
      check({tag, "_complete"}, 64'(done), 64'd1);
      check({tag, "_stall"}, 64'(stall), 64'(exp_stall));
      if (!rd_n) begin
         ed = rd_q.pop_front();
         check({tag, "_rdata"}, 64'(MEM_DI), 64'(ed));
      end
      @(posedge CLK); #1;
      if (rel) begin
         {RAMH_CS_N, RAML_CS_N, ROM_CS_N} = 3'b111;
         @(posedge CLK); #1;
      end
   endtask

   initial begin
      int acc0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("rst_mem_di", 64'(MEM_DI), 64'd0);
      check("rst_req_valid", 64'(REQ_VALID), 64'd0);
      check("rst_req_wr", 64'(REQ_WR), 64'd0);
      check("rst_req_addr", 64'(REQ_ADDR), 64'd0);
      check("rst_req_be", 64'(REQ_BE), 64'd0);
      check("rst_req_wdata", 64'(REQ_WDATA), 64'd0);
      check("rst_wait_n", 64'(MEM_WAIT_N), 64'd1);
      @(posedge CLK); #1;
      RST = 1'b0;
      @(posedge CLK); #1;

      // Read miss in high RAM, then buffered hit
      rsp_dly = 2; rsp_word = 32'hDEADBEEF;
      exp_req_q.push_back({1'b0, 22'h200104, 4'hF, 32'h0});
      rd_q.push_back(32'hDEADBEEF);
      access("rd_miss", 3'b011, 25'h0000104, 1'b0, 4'h0, 32'h0, 4, 1'b1);
      rsp_word = 32'hBAD0BAD0;
      acc0 = n_acc;
      rd_q.push_back(32'hDEADBEEF);
      access("rd_hit", 3'b011, 25'h0000104, 1'b0, 4'h0, 32'h0, 1, 1'b1);
      check("rd_hit_noreq", 64'(n_acc - acc0), 64'd0);

      // Partial write to the buffered word, then the read must miss again
      exp_req_q.push_back({1'b1, 22'h200104, 4'b0011, 32'h00001234});
      access("wr_inval", 3'b011, 25'h0000106, 1'b1, 4'b1100, 32'h00001234, 2, 1'b1);
      rsp_word = 32'hCAFEF00D;
      exp_req_q.push_back({1'b0, 22'h200104, 4'hF, 32'h0});
      rd_q.push_back(32'hCAFEF00D);
      access("rd_after_wr", 3'b011, 25'h0000104, 1'b0, 4'h0, 32'h0, 4, 1'b1);

      // Dropped writes: ROM region, and fully masked
      acc0 = n_acc;
      access("rom_wr", 3'b110, 25'h0000010, 1'b1, 4'h0, 32'h11111111, 1, 1'b1);
      access("mask_wr", 3'b101, 25'h0000020, 1'b1, 4'hF, 32'h22222222, 1, 1'b1);
      check("drop_noreq", 64'(n_acc - acc0), 64'd0);
      check("drop_mem_di_held", 64'(MEM_DI), 64'hCAFEF00D);

      // Backpressure: READY held off for 5 cycles
      ready_dly = 5; rsp_word = 32'h11223344;
      exp_req_q.push_back({1'b0, 22'h100040, 4'hF, 32'h0});
      rd_q.push_back(32'h11223344);
      access("bp_rd", 3'b101, 25'h0000040, 1'b0, 4'h0, 32'h0, 9, 1'b1);
      ready_dly = 0;

      // Back-to-back in low RAM with CS held, zero-wait controller
      rsp_dly = 1; rsp_word = 32'hA0A0A0A0;
      exp_req_q.push_back({1'b0, 22'h100000, 4'hF, 32'h0});
      rd_q.push_back(32'hA0A0A0A0);
      access("b2b_0", 3'b101, 25'h0000000, 1'b0, 4'h0, 32'h0, 3, 1'b0);
      rsp_word = 32'hB4B4B4B4;
      exp_req_q.push_back({1'b0, 22'h100004, 4'hF, 32'h0});
      rd_q.push_back(32'hB4B4B4B4);
      access("b2b_1", 3'b101, 25'h0000004, 1'b0, 4'h0, 32'h0, 3, 1'b1);

      // RAML and RAMH both selected: high RAM wins
      rsp_word = 32'h77777777;
      exp_req_q.push_back({1'b0, 22'h200008, 4'hF, 32'h0});
      rd_q.push_back(32'h77777777);
      access("prio", 3'b001, 25'h0000008, 1'b0, 4'h0, 32'h0, 3, 1'b1);

      // Reset while waiting for read data; the late response must be ignored
      rsp_dly = 4; rsp_word = 32'h55AA55AA;
      exp_req_q.push_back({1'b0, 22'h200200, 4'hF, 32'h0});
      {RAMH_CS_N, RAML_CS_N, ROM_CS_N} = 3'b011;
      MEM_A = 25'h0000200; MEM_RD_N = 1'b0; MEM_DQM_N = 4'h0;
      acc0 = n_acc;
      for (int i = 0; i < 20 && n_acc == acc0; i++) @(negedge CLK);
      check("rst_mid_accept", 64'(n_acc - acc0), 64'd1);
      RST = 1'b1;
      {RAMH_CS_N, RAML_CS_N, ROM_CS_N} = 3'b111;
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      check("rst_mid_req_valid", 64'(REQ_VALID), 64'd0);
      check("rst_mid_mem_di", 64'(MEM_DI), 64'd0);
      check("rst_mid_wait_n", 64'(MEM_WAIT_N), 64'd1);
      repeat (6) @(negedge CLK);
      check("stray_rsp_mem_di", 64'(MEM_DI), 64'd0);
      check("stray_rsp_req_valid", 64'(REQ_VALID), 64'd0);
      @(posedge CLK); #1;

      // Buffer was cleared by reset: a previously buffered word must miss
      rsp_dly = 1; rsp_word = 32'h99999999;
      acc0 = n_acc;
      exp_req_q.push_back({1'b0, 22'h200008, 4'hF, 32'h0});
      rd_q.push_back(32'h99999999);
      access("post_rst_rd", 3'b011, 25'h0000008, 1'b0, 4'h0, 32'h0, 3, 1'b1);
      check("post_rst_req", 64'(n_acc - acc0), 64'd1);

      repeat (2) @(posedge CLK);
      check("req_q_drained", 64'(exp_req_q.size()), 64'd0);
      check("rd_q_drained", 64'(rd_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
